// File: rtl/pwm_multi_if.sv
// pwm_multi_if
//   Groups the run-control, configuration and PWM output signals of
//   pwm_multi into one bundle. The config source or control FSM uses the
//   master view. The PWM block uses the slave view.
//
//   Signals:
//     en          run enable (master -> slave)
//     cfg_we      config write strobe, one cycle per write (master -> slave)
//     cfg_sel     0 selects TOP, k selects the duty of channel k-1
//     cfg_data    write data, WIDTH bits
//     y           registered PWM outputs, N_CH bits (slave -> master)
//     cycle_start one-cycle pulse at the start of each period
//     upd_pending a shadow register holds a value not yet committed
interface pwm_multi_if #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned SEL_W = $clog2(N_CH + 1);

  logic              en;
  logic              cfg_we;
  logic [SEL_W-1:0]  cfg_sel;
  logic [WIDTH-1:0]  cfg_data;
  logic [N_CH-1:0]   y;
  logic              cycle_start;
  logic              upd_pending;

  modport master (
    output en, cfg_we, cfg_sel, cfg_data,
    input  y, cycle_start, upd_pending
  );

  modport slave (
    input  en, cfg_we, cfg_sel, cfg_data,
    output y, cycle_start, upd_pending
  );
endinterface

// File: rtl/pwm_multi.sv
// pwm_multi
//   N-channel PWM generator. All channels share one free-running period
//   counter. The period (TOP) and the per-channel duty values are written
//   into shadow registers. They are copied into the active registers at the
//   period boundary, or on any cycle with en low. Every channel switches in
//   the same cycle, so a single period never mixes old and new settings.
//
//   Ports:
//     clk   system clock, rising edge
//     rst   synchronous, active-high reset
//     bus   pwm_multi_if.slave (en, cfg_we/cfg_sel/cfg_data in;
//           y, cycle_start, upd_pending out, all registered)
//
//   Build option:
//     PWM_CENTER_EN  when defined, the counter runs up/down
//                    (0,1..TOP,TOP-1..1,0...). Pulses are then centred on
//                    cnt==0, and commits happen at cnt==0 on the down-count.
//                    When undefined, the counter is an edge-aligned
//                    up-counter with a period of TOP+1 clocks.
module pwm_multi #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEF_TOP = 9
) (
  input logic        clk,
  input logic        rst,
  pwm_multi_if.slave bus
);
  localparam int unsigned     SEL_W   = $clog2(N_CH + 1);
  localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(N_CH);
  localparam logic [WIDTH-1:0] TOP_RST = WIDTH'(DEF_TOP);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0]            cnt_q, cnt_d;
  logic [WIDTH-1:0]            top_act_q, top_act_d;
  logic [WIDTH-1:0]            top_sh_q, top_sh_d;
  logic [N_CH-1:0][WIDTH-1:0]  duty_act_q, duty_act_d;
  logic [N_CH-1:0][WIDTH-1:0]  duty_sh_q, duty_sh_d;
  logic [N_CH-1:0]             y_q, y_d;
  logic                        cycle_start_q, cycle_start_d;
  logic                        upd_pending_q, upd_pending_d;
  logic                        commit;
  logic                        wr_valid;

`ifdef PWM_CENTER_EN
  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;
  dir_e dir_q, dir_d;
`endif

  // Period counter and commit trigger. A disabled block parks the counter
  // at 0 and commits every cycle, so a restart always begins a full period
  // with the latest settings. The centre-aligned counter rests "down" at 0.
  // Reaching 0 on the way down is therefore both the commit point and the
  // turn-around point. The restart value comes from the TOP being committed,
  // so a new TOP of 0 keeps the counter at 0.
  always_comb begin
    cnt_d  = cnt_q;
    commit = 1'b0;
`ifdef PWM_CENTER_EN
    dir_d  = dir_q;
`endif
    if (!bus.en) begin
      cnt_d  = '0;
      commit = 1'b1;
`ifdef PWM_CENTER_EN
      dir_d  = DIR_DOWN;
`endif
    end else begin
`ifdef PWM_CENTER_EN
      if (dir_q == DIR_UP) begin
        if (cnt_q == top_act_q) begin
          cnt_d = (top_act_q == '0) ? '0 : cnt_q - ONE;
          dir_d = DIR_DOWN;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else begin
        if (cnt_q == '0) begin
          commit = 1'b1;
          if (top_sh_q != '0) begin
            cnt_d = ONE;
            dir_d = DIR_UP;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
`else
      if (cnt_q == top_act_q) begin
        cnt_d  = '0;
        commit = 1'b1;
      end else begin
        cnt_d  = cnt_q + ONE;
      end
`endif
    end
  end

  // Shadow writes and the active-register commit. A commit copies the
  // pre-write shadow contents. A write in the same cycle therefore waits
  // in the shadow for the next boundary and keeps upd_pending set.
  // Selects beyond the last channel are dropped and change no state.
  always_comb begin
    wr_valid  = bus.cfg_we && (bus.cfg_sel <= MAX_SEL);
    top_sh_d  = top_sh_q;
    duty_sh_d = duty_sh_q;
    if (wr_valid) begin
      if (bus.cfg_sel == '0) begin
        top_sh_d = bus.cfg_data;
      end
      for (int i = 0; i < int'(N_CH); i++) begin
        if (bus.cfg_sel == SEL_W'(i + 1)) begin
          duty_sh_d[i] = bus.cfg_data;
        end
      end
    end
    top_act_d  = commit ? top_sh_q  : top_act_q;
    duty_act_d = commit ? duty_sh_q : duty_act_q;
    if (wr_valid) begin
      upd_pending_d = 1'b1;
    end else if (commit) begin
      upd_pending_d = 1'b0;
    end else begin
      upd_pending_d = upd_pending_q;
    end
  end

  // Output compare. The outputs follow the counter by one clock.
  // A duty above TOP never fails the compare, so the channel stays high.
  always_comb begin
    y_d = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      y_d[i] = bus.en && (cnt_q < duty_act_q[i]);
    end
    cycle_start_d = bus.en && (cnt_q == '0);
  end

  // State registers. Reset restores the default period and zero duty on
  // the next edge, so no partial pulse survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      top_act_q     <= TOP_RST;
      top_sh_q      <= TOP_RST;
      duty_act_q    <= '0;
      duty_sh_q     <= '0;
      y_q           <= '0;
      cycle_start_q <= 1'b0;
      upd_pending_q <= 1'b0;
`ifdef PWM_CENTER_EN
      dir_q         <= DIR_DOWN;
`endif
    end else begin
      cnt_q         <= cnt_d;
      top_act_q     <= top_act_d;
      top_sh_q      <= top_sh_d;
      duty_act_q    <= duty_act_d;
      duty_sh_q     <= duty_sh_d;
      y_q           <= y_d;
      cycle_start_q <= cycle_start_d;
      upd_pending_q <= upd_pending_d;
`ifdef PWM_CENTER_EN
      dir_q         <= dir_d;
`endif
    end
  end

  assign bus.y           = y_q;
  assign bus.cycle_start = cycle_start_q;
  assign bus.upd_pending = upd_pending_q;

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi
//   Scoreboard bench for pwm_multi. On every clock the stimulus side
//   predicts the outputs and queues them. The waveform model works one
//   period at a time: at each period start it lays out the whole expected
//   output sequence from the committed TOP and duty values. A monitor
//   process pops each prediction and compares it with the DUT after every
//   rising edge.
module tb_pwm_multi;
  localparam int N_CH    = 4;
  localparam int WIDTH   = 8;
  localparam int DEF_TOP = 9;
  localparam int SEL_W   = $clog2(N_CH + 1);

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pwm_multi_if #(.N_CH(N_CH), .WIDTH(WIDTH)) bus ();

  pwm_multi #(.N_CH(N_CH), .WIDTH(WIDTH), .DEF_TOP(DEF_TOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [N_CH-1:0] y;
    logic            cs;
    logic            last;
  } slotT;

  typedef struct packed {
    logic [N_CH-1:0] y;
    logic            cs;
    logic            pend;
  } expT;

  slotT waveQ[$];
  expT  expQ[$];

  int mTop;
  int sTop;
  int mDuty [N_CH];
  int sDuty [N_CH];
  bit mPend;
  bit mFresh;

  int checks   = 0;
  int failures = 0;

  // Builds one output slot for the counter value k, using the committed
  // duty values.
  function automatic slotT makeSlot(int k, bit last);
    slotT s;
    s = '0;
    for (int i = 0; i < N_CH; i++) s.y[i] = (k < mDuty[i]);
    s.cs   = (k == 0);
    s.last = last;
    return s;
  endfunction

  // Lays out the full output sequence of the next period. The last slot is
  // the one whose edge performs the commit.
  function automatic void buildPeriod();
`ifdef PWM_CENTER_EN
    if (mFresh || mTop == 0) begin
      waveQ.push_back(makeSlot(0, 1'b1));
      mFresh = 1'b0;
    end else begin
      for (int k = 1; k <= mTop; k++) waveQ.push_back(makeSlot(k, 1'b0));
      for (int k = mTop - 1; k >= 0; k--) waveQ.push_back(makeSlot(k, k == 0));
    end
`else
    for (int k = 0; k <= mTop; k++) waveQ.push_back(makeSlot(k, k == mTop));
`endif
  endfunction

  // Advances the reference model by one clock edge and queues the outputs
  // the DUT should present after that edge.
  function automatic void modelStep(bit r, bit e, bit w, int sel, int data);
    expT  x;
    slotT s;
    bit   commit;
    bit   wrOk;
    x      = '0;
    commit = 1'b0;
    if (r) begin
      mTop = DEF_TOP;
      sTop = DEF_TOP;
      for (int i = 0; i < N_CH; i++) begin
        mDuty[i] = 0;
        sDuty[i] = 0;
      end
      mPend  = 1'b0;
      mFresh = 1'b1;
      waveQ.delete();
    end else begin
      if (!e) begin
        commit = 1'b1;
        mFresh = 1'b1;
        waveQ.delete();
      end else begin
        if (waveQ.size() == 0) buildPeriod();
        s      = waveQ.pop_front();
        x.y    = s.y;
        x.cs   = s.cs;
        commit = s.last;
      end
      if (commit) begin
        mTop = sTop;
        for (int i = 0; i < N_CH; i++) mDuty[i] = sDuty[i];
      end
      wrOk = w && (sel <= N_CH);
      if (wrOk) begin
        if (sel == 0) sTop = data;
        else sDuty[sel-1] = data;
        mPend = 1'b1;
      end else if (commit) begin
        mPend = 1'b0;
      end
    end
    x.pend = mPend;
    expQ.push_back(x);
  endfunction

  // Drives one cycle of inputs well before the rising edge and records the
  // matching prediction.
  task automatic applyStimulus(bit r, bit e, bit w, int sel, int data);
    @(negedge clk);
    rst          = r;
    bus.en       = e;
    bus.cfg_we   = w;
    bus.cfg_sel  = SEL_W'(sel);
    bus.cfg_data = WIDTH'(data);
    modelStep(r, e, w, sel, data);
  endtask

  // Compares the DUT outputs with the oldest queued prediction.
  task automatic checkOutput();
    expT x;
    x = expQ.pop_front();
    checks++;
    if (bus.y !== x.y) begin
      failures++;
      $display("[TB] FAIL y t=%0t got=%b exp=%b", $time, bus.y, x.y);
    end
    checks++;
    if (bus.cycle_start !== x.cs) begin
      failures++;
      $display("[TB] FAIL cycle_start t=%0t got=%b exp=%b", $time, bus.cycle_start, x.cs);
    end
    checks++;
    if (bus.upd_pending !== x.pend) begin
      failures++;
      $display("[TB] FAIL upd_pending t=%0t got=%b exp=%b", $time, bus.upd_pending, x.pend);
    end
  endtask

  // Monitor: checks the DUT after every rising edge that has a prediction.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) checkOutput();
    end
  end

  // Runs idle cycles until the next edge is the given slot of the period,
  // with a bounded number of cycles.
  task automatic runToRemaining(int remaining);
    for (int i = 0; i < 600 && waveQ.size() != remaining; i++)
      applyStimulus(1'b0, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic runIdle(int n, bit e);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, e, 1'b0, 0, 0);
  endtask

  initial begin
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_sel  = '0;
    bus.cfg_data = '0;

    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);

    // Duty programming while disabled, then a run with the default period.
    applyStimulus(1'b0, 1'b0, 1'b1, 1, 3);
    applyStimulus(1'b0, 1'b0, 1'b1, 2, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 3, 10);
    applyStimulus(1'b0, 1'b0, 1'b1, 4, 255);
    runIdle(2, 1'b0);
    runIdle(25, 1'b1);

    // Duty change in the middle of a period (counter at 4).
    runToRemaining(mTop + 1 - 4);
    applyStimulus(1'b0, 1'b1, 1'b1, 1, 7);
    runIdle(25, 1'b1);

    // TOP lowered mid-period (counter at 2), then a write on the last clock.
    runToRemaining(mTop + 1 - 2);
    applyStimulus(1'b0, 1'b1, 1'b1, 0, 4);
    runIdle(20, 1'b1);
    runToRemaining(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1, 2);
    runIdle(15, 1'b1);

    // Reset in the middle of a period, then a write to a nonexistent channel.
    applyStimulus(1'b0, 1'b1, 1'b1, 0, 9);
    runIdle(12, 1'b1);
    runToRemaining(mTop + 1 - 6);
    applyStimulus(1'b1, 1'b1, 1'b1, 1, 5);
    applyStimulus(1'b0, 1'b1, 1'b1, 7, 99);
    runIdle(12, 1'b1);

    // TOP=0, en dropping mid-period, and a centred-pulse style setting.
    applyStimulus(1'b0, 1'b1, 1'b1, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1, 1);
    runIdle(15, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 0, 5);
    applyStimulus(1'b0, 1'b0, 1'b1, 1, 2);
    runIdle(1, 1'b0);
    runIdle(7, 1'b1);
    runIdle(1, 1'b0);
    runIdle(30, 1'b1);

    // Randomised traffic.
    for (int n = 0; n < 1500; n++) begin
      bit r, e, w;
      int sel, data;
      r   = ($urandom_range(0, 199) == 0);
      e   = ($urandom_range(0, 19) != 0);
      w   = ($urandom_range(0, 5) == 0);
      sel = $urandom_range(0, 7);
      if (sel == 0) data = $urandom_range(0, 12);
      else if ($urandom_range(0, 7) == 0) data = 255;
      else data = $urandom_range(0, 15);
      applyStimulus(r, e, w, sel, data);
    end
    runIdle(3, 1'b1);

    @(posedge clk);
    #2;
    for (int i = 0; i < 10 && expQ.size() != 0; i++) begin
      @(posedge clk);
      #2;
    end
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain left=%0d exp=0", expQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Parametrised successor to the team's single-channel fixed-ratio PWM: N channels sharing one free-running period counter.
- Runtime-programmable period and per-channel duty, held in shadow registers and applied glitch-free at the period boundary.
- Sits between a control FSM/config source and output drivers (LEDs, motor gates); one clock domain.

Parameters:
- N_CH, 4, number of PWM output channels (1..16)
- WIDTH, 8, width of counter, period (TOP) and duty values
- DEF_TOP, 9, reset value of TOP; period = TOP+1 clocks

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  run enable; 0 holds counter at 0 and forces outputs low
- cfg_we  in  1  config write strobe, one cycle per write
- cfg_sel  in  $clog2(N_CH+1)  0 = TOP, k = duty of channel k-1
- cfg_data  in  WIDTH  write data
- y  out  N_CH  PWM outputs, registered
- cycle_start  out  1  one-cycle pulse, registered, when cnt==0 while en=1
- upd_pending  out  1  shadow written but not yet committed

Behaviour:
- Reset (rst=1 at clk edge): cnt=0, top_act=top_sh=DEF_TOP, duty_act[*]=duty_sh[*]=0, y=0, cycle_start=0, upd_pending=0. Reset mid-period takes effect at the next edge, with no partial pulse.
- Counter, when en=1: cnt <= (cnt==top_act) ? 0 : cnt+1. When en=0: cnt <= 0.
- Output: y[i] <= en & (cnt < duty_act[i]), an unsigned compare at WIDTH bits. One cycle latency from cnt. In steady state y[i] is high for exactly min(D, TOP+1) clocks of every TOP+1 clocks, starting at the period start.
- Boundary values:
  - D=0: y[i] constantly 0.
  - D>TOP: y[i] constantly 1 (100%).
  - TOP=0: period of 1 clock; y[i] = (D>0).
- cycle_start <= en & (cnt==0).
- Config write (cfg_we=1): cfg_data goes to top_sh (sel 0) or duty_sh[sel-1]. cfg_sel > N_CH is ignored, with no state change. The write sets upd_pending=1.
- Commit:
  - Trigger: en=1 & cnt==top_act (last clock of the period), or any cycle with en=0.
  - Action: top_act <= top_sh, all duty_act <= duty_sh, upd_pending <= 0.
  - All channels commit atomically; a period never mixes old and new values.
- Simultaneous write and commit: the commit uses the pre-write shadow values. The new value stays in shadow and upd_pending stays/goes 1, so it commits at the next boundary.
- TOP is lowered below the current cnt only via shadow, so wrap-around is always well defined.
- en falling mid-period: the next edge gives cnt=0, y=0, and shadows commit. en rising: counting starts from cnt=0; the first period is full length.

Optional Feature:
- Macro: PWM_CENTER_EN.
- Defined:
  - Counter is up/down: 0,1..TOP,TOP-1..1,0..., so period = 2*TOP clocks (TOP=0 → cnt stays 0).
  - y[i] <= en & (cnt < duty_act[i]), giving a pulse centred on cnt==0 of width 2*D-1 clocks for 0<D<=TOP. D>TOP gives 100%.
  - Commit occurs only at cnt==0 on a down-count (and when en=0).
  - cycle_start pulses at cnt==0.
- Undefined: edge-aligned up-counter exactly as above, with no up/down logic synthesised.

Test Plan:
- Reset then en=1, defaults (TOP=9), write duty ch0=3 while en=0 → from first period y[0] high 3 clocks / low 7 clocks, repeating; cycle_start every 10 clocks; y[3:1]=0.
- Duty ch1=0 and ch2=10, ch3=255 → y[1] never high; y[2], y[3] constantly high while en=1.
- At cnt=4 with ch0 duty 3, write duty 7 → current period still 3 high; upd_pending=1 until the cnt==9 edge; next period 7 high.
- Write TOP=4 mid-period at cnt=2 → current period completes 10 clocks; subsequent periods 5 clocks, cycle_start spacing 5; a write landing exactly at cnt==top_act is deferred one extra period.
- Assert rst for 1 cycle at cnt=6 with y[0] active → next edge all outputs 0, TOP back to 9, duties 0; cfg_sel=7 (invalid, N_CH=4) write ignored.
- PWM_CENTER_EN, TOP=5, D=2 → period 10 clocks, y[0] high 3 consecutive clocks centred on cnt==0.
